seg_page_sched: RTL and testbench



---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_page_sched_if.sv | 34 +++
 rtl/seg_ms_tick.sv | 32 +++
 rtl/seg_page_sched.sv | 151 +++++++++++++++
 tb/tb_seg_page_sched.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display slice.
// Also holds the next-enabled-page helper used by the scheduler.
package seg_pkg;

  localparam logic [3:0] SEG_BLANK = 4'hF;
  localparam int         NUM_PAGES = 3;

  typedef enum logic [0:0] {
    PAGE = 1'b0,
    MSG  = 1'b1
  } sched_state_e;

  typedef logic [1:0] page_idx_t;

  // First enabled page above cur (wrapping 2 -> 0); cur itself if no other is enabled.
  function automatic page_idx_t next_page(input page_idx_t cur, input logic [2:0] en);
    page_idx_t cand1;
    page_idx_t cand2;
    page_idx_t res;
    cand1 = (cur >= 2'd2) ? 2'd0 : cur + 2'd1;
    cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
    res   = cur;
    if (en[cand1]) begin
      res = cand1;
    end else if (en[cand2]) begin
      res = cand2;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_page_sched_if.sv
// Bus between the page/message producers and the display scheduler.
interface seg_page_sched_if;
  import seg_pkg::*;

  logic [31:0]  page0_data;
  logic [31:0]  page1_data;
  logic [31:0]  page2_data;
  logic [2:0]   page_en;
  logic         key_next;
  // Message handshake: the producer raises msg_req and holds it with msg_data
  // stable; the scheduler pulses msg_ack for one cycle when msg_data is latched,
  // and the producer must drop msg_req (or present a new message) after that cycle.
  logic         msg_req;
  logic [31:0]  msg_data;
  logic         msg_ack;
  logic [7:0]   blink_mask;
  logic [31:0]  dsp_data;
  page_idx_t    cur_page;
  logic         msg_busy;
  sched_state_e dbg_state;

  modport slave (
    input  page0_data, page1_data, page2_data, page_en, key_next,
    input  msg_req, msg_data, blink_mask,
    output msg_ack, dsp_data, cur_page, msg_busy, dbg_state
  );

  modport master (
    output page0_data, page1_data, page2_data, page_en, key_next,
    output msg_req, msg_data, blink_mask,
    input  msg_ack, dsp_data, cur_page, msg_busy, dbg_state
  );

endinterface

// File: rtl/seg_ms_tick.sv
// Free-running divider: one-cycle tick every TICK_MAX clocks.
module seg_ms_tick #(
  parameter int TICK_MAX = 50000
) (
  input  logic seg_clk,
  input  logic seg_rst,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_MAX - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge seg_clk or negedge seg_rst) begin
    if (!seg_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/seg_page_sched.sv
// Chooses the word shown on the 8-digit display: rotating pages, manual advance,
// pre-empting one-shot messages and per-digit blinking.
module seg_page_sched
  import seg_pkg::*;
#(
  parameter int TICK_MAX  = 50000,
  parameter int ROTATE_MS = 2000,
  parameter int MSG_MS    = 1000,
  parameter int BLINK_MS  = 500
) (
  input  logic              seg_clk,
  input  logic              seg_rst,
  seg_page_sched_if.slave   bus
);

  localparam logic [11:0] ROT_LAST   = 12'(ROTATE_MS - 1);
  localparam logic [11:0] MSG_LAST   = 12'(MSG_MS - 1);
  localparam logic [11:0] BLINK_LAST = 12'(BLINK_MS - 1);

  logic tick;

  seg_ms_tick #(.TICK_MAX(TICK_MAX)) u_tick (
    .seg_clk (seg_clk),
    .seg_rst (seg_rst),
    .tick    (tick)
  );

  sched_state_e state_q, state_d;
  page_idx_t    page_q, page_d;
  logic [11:0]  rot_q, rot_d;
  logic [11:0]  msg_t_q, msg_t_d;
  logic [11:0]  blink_t_q, blink_t_d;
  logic         blink_on_q, blink_on_d;
  logic [31:0]  msg_q, msg_d;
  logic [31:0]  dsp_q, dsp_d;
  logic         ack_q, ack_d;
  logic         busy_q, busy_d;

  page_idx_t    nxt;
  logic         rot_expire;
  logic         advance;
  logic [31:0]  page_word;

  always_ff @(posedge seg_clk or negedge seg_rst) begin
    if (!seg_rst) begin
      state_q    <= PAGE;
      page_q     <= '0;
      rot_q      <= '0;
      msg_t_q    <= '0;
      blink_t_q  <= '0;
      blink_on_q <= 1'b1;
      msg_q      <= '1;
      dsp_q      <= '1;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      rot_q      <= rot_d;
      msg_t_q    <= msg_t_d;
      blink_t_q  <= blink_t_d;
      blink_on_q <= blink_on_d;
      msg_q      <= msg_d;
      dsp_q      <= dsp_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    rot_d      = rot_q;
    msg_t_d    = msg_t_q;
    blink_t_d  = blink_t_q;
    blink_on_d = blink_on_q;
    msg_d      = msg_q;
    ack_d      = 1'b0;
    busy_d     = (state_q == MSG);

    nxt        = next_page(page_q, bus.page_en);
    rot_expire = tick && (rot_q == ROT_LAST);
    // A disabled current page only moves when somewhere else is enabled.
    advance    = rot_expire || bus.key_next ||
                 (!bus.page_en[page_q] && (nxt != page_q));

    if (tick) begin
      if (blink_t_q == BLINK_LAST) begin
        blink_t_d  = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        blink_t_d = blink_t_q + 12'd1;
      end
    end

    unique case (state_q)
      PAGE: begin
        if (bus.msg_req) begin
          state_d = MSG;
          msg_d   = bus.msg_data;
          ack_d   = 1'b1;
          msg_t_d = '0;
        end else if (advance) begin
          page_d = nxt;
          rot_d  = '0;
        end else if (tick) begin
          rot_d = rot_q + 12'd1;
        end
      end
      MSG: begin
        if (tick) begin
          if (msg_t_q == MSG_LAST) begin
            state_d = PAGE;
            msg_t_d = '0;
            rot_d   = '0;
          end else begin
            msg_t_d = msg_t_q + 12'd1;
          end
        end
      end
      default: state_d = PAGE;
    endcase
  end

  always_comb begin
    page_word = '1;
    dsp_d     = '1;
    unique case (page_q)
      2'd0:    page_word = bus.page0_data;
      2'd1:    page_word = bus.page1_data;
      default: page_word = bus.page2_data;
    endcase

    if (state_q == MSG) begin
      dsp_d = msg_q;
    end else if (bus.page_en != 3'b000) begin
      // blink_mask bit i maps to nibble [4i+3:4i], so bit 7 is the leftmost digit.
      for (int i = 0; i < 8; i++) begin
        dsp_d[4*i +: 4] = (bus.blink_mask[i] && !blink_on_q) ? SEG_BLANK
                                                             : page_word[4*i +: 4];
      end
    end
  end

  assign bus.dsp_data  = dsp_q;
  assign bus.cur_page  = page_q;
  assign bus.msg_ack   = ack_q;
  assign bus.msg_busy  = busy_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_seg_page_sched.sv
// Directed bench for seg_page_sched with short timers (4-clock ms tick).
module tb_seg_page_sched;
  import seg_pkg::*;

  logic seg_clk;
  logic seg_rst;
  int   cyc;
  int   total;
  int   passed;
  int   failed;

  seg_page_sched_if bus ();

  seg_page_sched #(
    .TICK_MAX  (4),
    .ROTATE_MS (3),
    .MSG_MS    (2),
    .BLINK_MS  (2)
  ) dut (
    .seg_clk (seg_clk),
    .seg_rst (seg_rst),
    .bus     (bus)
  );

  initial begin
    seg_clk = 1'b0;
    forever #5 seg_clk = ~seg_clk;
  end

  // cyc counts rising edges since the last reset release; sampled on the falling edge.
  task automatic step(input int k);
    repeat (k) begin
      @(negedge seg_clk);
      cyc++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    cyc    = 0;
    seg_rst            = 1'b0;
    bus.page0_data     = 32'h1111_1111;
    bus.page1_data     = 32'h2222_2222;
    bus.page2_data     = 32'h3333_3333;
    bus.page_en        = 3'b101;
    bus.key_next       = 1'b0;
    bus.msg_req        = 1'b0;
    bus.msg_data       = 32'h0;
    bus.blink_mask     = 8'h00;

    // reset values
    repeat (3) @(negedge seg_clk);
    check("rst_dsp",   bus.dsp_data, 32'hFFFF_FFFF);
    check("rst_page",  32'(bus.cur_page), 32'd0);
    check("rst_ack",   32'(bus.msg_ack), 32'd0);
    check("rst_busy",  32'(bus.msg_busy), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(PAGE));

    seg_rst = 1'b1;
    cyc     = 0;
    #1 check("rel_blank", bus.dsp_data, 32'hFFFF_FFFF);
    step(1);
    check("rel_page0", bus.dsp_data, 32'h1111_1111);
    check("rel_cur",   32'(bus.cur_page), 32'd0);

    // rotation with page 1 disabled: advances at edges 12 and 24
    while (cyc < 25) begin
      step(1);
      check("rot_dsp", bus.dsp_data,
            (cyc < 13) ? 32'h1111_1111 : (cyc < 25) ? 32'h3333_3333 : 32'h1111_1111);
      check("rot_cur", 32'(bus.cur_page), (cyc < 12) ? 32'd0 : (cyc < 24) ? 32'd2 : 32'd0);
    end

    // key_next coincides with rotate expiry at edge 36
    bus.page_en = 3'b111;
    while (cyc < 35) step(1);
    bus.key_next = 1'b1;
    step(1);
    bus.key_next = 1'b0;
    check("collide_once", 32'(bus.cur_page), 32'd1);
    while (cyc < 47) step(1);
    check("rot_restart_hold", 32'(bus.cur_page), 32'd1);
    step(1);
    check("rot_restart_exp", 32'(bus.cur_page), 32'd2);

    // manual advance with wrap
    step(1);
    bus.key_next = 1'b1;
    step(1);
    check("key_wrap", 32'(bus.cur_page), 32'd0);
    step(1);
    check("key_adv", 32'(bus.cur_page), 32'd1);
    bus.key_next = 1'b0;

    // message pre-emption on page 1, accepted on the tick edge 56
    while (cyc < 55) step(1);
    check("pre_ack", 32'(bus.msg_ack), 32'd0);
    bus.msg_req  = 1'b1;
    bus.msg_data = 32'h9876_5432;
    step(1);
    check("msg_ack",      32'(bus.msg_ack), 32'd1);
    check("msg_busy_lag", 32'(bus.msg_busy), 32'd0);
    check("msg_dsp_lag",  bus.dsp_data, 32'h2222_2222);
    bus.msg_req = 1'b0;
    while (cyc < 64) begin
      step(1);
      check("msg_dsp",  bus.dsp_data, 32'h9876_5432);
      check("msg_busy", 32'(bus.msg_busy), 32'd1);
      check("msg_noack", 32'(bus.msg_ack), 32'd0);
      if (cyc == 59) bus.key_next = 1'b1;
      if (cyc == 60) bus.key_next = 1'b0;
      if (cyc == 62) begin
        bus.msg_req  = 1'b1;
        bus.msg_data = 32'h1357_2468;
      end
    end
    check("msg_key_ignored", 32'(bus.cur_page), 32'd1);
    step(1);
    check("msg2_ack",     32'(bus.msg_ack), 32'd1);
    check("msg2_gap_dsp", bus.dsp_data, 32'h2222_2222);
    check("msg2_gap_busy", 32'(bus.msg_busy), 32'd0);
    bus.msg_req = 1'b0;
    step(1);
    check("msg2_dsp",  bus.dsp_data, 32'h1357_2468);
    check("msg2_busy", 32'(bus.msg_busy), 32'd1);
    check("msg2_ack_pulse", 32'(bus.msg_ack), 32'd0);
    step(1);

    // reset in the middle of the second message
    seg_rst = 1'b0;
    #1;
    check("mid_rst_dsp",   bus.dsp_data, 32'hFFFF_FFFF);
    check("mid_rst_busy",  32'(bus.msg_busy), 32'd0);
    check("mid_rst_ack",   32'(bus.msg_ack), 32'd0);
    check("mid_rst_cur",   32'(bus.cur_page), 32'd0);
    check("mid_rst_state", 32'(bus.dbg_state), 32'(PAGE));

    // blink on a single page: phase off for edges 8..15, on 16..23, ...
    bus.page0_data = 32'h1234_5678;
    bus.page_en    = 3'b001;
    bus.blink_mask = 8'h81;
    @(negedge seg_clk);
    @(negedge seg_clk);
    seg_rst = 1'b1;
    cyc     = 0;
    while (cyc < 32) begin
      step(1);
      check("blink_dsp", bus.dsp_data,
            ((((cyc - 1) / 8) % 2) == 1) ? 32'hF234_567F : 32'h1234_5678);
    end
    while (cyc < 39) step(1);
    bus.msg_req  = 1'b1;
    bus.msg_data = 32'h9876_5432;
    step(1);
    check("blink_msg_ack", 32'(bus.msg_ack), 32'd1);
    bus.msg_req = 1'b0;
    while (cyc < 48) begin
      step(1);
      check("blink_msg_dsp", bus.dsp_data, 32'h9876_5432);
    end
    step(1);
    check("blink_msg_back", bus.dsp_data, 32'h1234_5678);

    // no enabled pages
    seg_rst        = 1'b0;
    bus.page_en    = 3'b000;
    bus.blink_mask = 8'h00;
    @(negedge seg_clk);
    @(negedge seg_clk);
    seg_rst = 1'b1;
    cyc     = 0;
    step(3);
    check("none_dsp", bus.dsp_data, 32'hFFFF_FFFF);
    check("none_cur", 32'(bus.cur_page), 32'd0);

    // current page disabled while another is enabled
    bus.page_en = 3'b010;
    step(1);
    check("dis_adv_cur", 32'(bus.cur_page), 32'd1);
    step(1);
    check("dis_adv_dsp", bus.dsp_data, 32'h2222_2222);
    bus.page1_data = 32'h0000_0042;
    step(1);
    check("page_data_lat", bus.dsp_data, 32'h0000_0042);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
